// File: rtl/l1_threshold_servo.sv
// l1_threshold_servo: Wishbone host that servos per-beam L1 trigger thresholds
// toward a target count rate. Each servo cycle starts a count, polls for done,
// then per beam reads the count, steps the threshold, writes and loads it, and
// finally applies all thresholds together.
// Optional ack watchdog: define L1_THRESH_SERVO_WB_TIMEOUT_EN.
module l1_threshold_servo #(
    parameter int unsigned NBEAMS         = 2,
    parameter logic [17:0] INIT_THRESH    = 18'd4096,
    parameter logic [17:0] THRESH_MIN     = 18'd16,
    parameter logic [17:0] THRESH_MAX     = 18'h3FFFF,
    parameter int unsigned POLL_INTERVAL  = 1024,
    parameter int unsigned TIMEOUT_CLOCKS = 64
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic                 enable_i,
    input  logic [31:0]          target_i,
    input  logic [31:0]          tol_i,
    input  logic [17:0]          step_i,
    output logic                 wb_cyc_o,
    output logic                 wb_stb_o,
    output logic                 wb_we_o,
    output logic [21:0]          wb_adr_o,
    output logic [31:0]          wb_dat_o,
    output logic [3:0]           wb_sel_o,
    input  logic [31:0]          wb_dat_i,
    input  logic                 wb_ack_i,
    input  logic                 wb_err_i,
    input  logic                 wb_rty_i,
    output logic                 busy_o,
    output logic                 cycle_done_o,
    output logic                 err_o,
    output logic [NBEAMS*18-1:0] thresh_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_WAIT, S_POLL, S_RDCNT,
        S_ADJ, S_WRTHR, S_LOAD, S_APPLY, S_FIN
    } state_t;

    state_t               state_q, state_d;
    logic                 cyc_q, cyc_d;
    logic                 we_q, we_d;
    logic [21:0]          adr_q, adr_d;
    logic [31:0]          dat_q, dat_d;
    logic [3:0]           sel_q, sel_d;
    logic                 busy_q, busy_d;
    logic                 cycle_done_q, cycle_done_d;
    logic                 err_q, err_d;
    logic [NBEAMS*18-1:0] thresh_q, thresh_d;
    logic [7:0]           beam_q, beam_d;
    logic [31:0]          wait_cnt_q, wait_cnt_d;
    logic [31:0]          count_q, count_d;
    logic [31:0]          target_q, target_d;
    logic [31:0]          tol_q, tol_d;
    logic [17:0]          step_q, step_d;
`ifdef L1_THRESH_SERVO_WB_TIMEOUT_EN
    logic [31:0]          to_cnt_q, to_cnt_d;
`endif

    logic                 is_bus_s;
    logic                 bus_we_s;
    logic [21:0]          bus_adr_s;
    logic [31:0]          bus_dat_s;
    logic [3:0]           bus_sel_s;
    logic [17:0]          cur_thr_s;
    logic [17:0]          new_thr_s;
    logic [32:0]          sum_hi_s;
    logic [31:0]          band_hi_s;
    logic [31:0]          band_lo_s;
    logic [18:0]          up_s;
    logic [18:0]          dn_s;

    assign wb_cyc_o     = cyc_q;
    assign wb_stb_o     = cyc_q;
    assign wb_we_o      = we_q;
    assign wb_adr_o     = adr_q;
    assign wb_dat_o     = dat_q;
    assign wb_sel_o     = sel_q;
    assign busy_o       = busy_q;
    assign cycle_done_o = cycle_done_q;
    assign err_o        = err_q;
    assign thresh_o     = thresh_q;

    // Select the threshold of the beam currently being serviced.
    always_comb begin
        cur_thr_s = 18'd0;
        for (int i = 0; i < int'(NBEAMS); i++) begin
            if (beam_q == 8'(i)) begin
                cur_thr_s = thresh_q[i*18 +: 18];
            end else begin
                cur_thr_s = cur_thr_s;
            end
        end
    end

    // Dead-band edges and saturating threshold step for the ADJ state.
    always_comb begin
        sum_hi_s  = {1'b0, target_q} + {1'b0, tol_q};
        band_hi_s = sum_hi_s[32] ? 32'hFFFF_FFFF : sum_hi_s[31:0];
        band_lo_s = (target_q >= tol_q) ? (target_q - tol_q) : 32'd0;
        up_s      = {1'b0, cur_thr_s} + {1'b0, step_q};
        dn_s      = {1'b0, cur_thr_s} - {1'b0, step_q};
        if (count_q > band_hi_s) begin
            new_thr_s = (up_s > {1'b0, THRESH_MAX}) ? THRESH_MAX : up_s[17:0];
        end else if (count_q < band_lo_s) begin
            new_thr_s = (dn_s[18] || (dn_s[17:0] < THRESH_MIN)) ? THRESH_MIN : dn_s[17:0];
        end else begin
            new_thr_s = cur_thr_s;
        end
    end

    // Transfer attributes presented by each bus-issuing state.
    always_comb begin
        is_bus_s  = 1'b1;
        bus_we_s  = 1'b0;
        bus_adr_s = 22'd0;
        bus_dat_s = 32'd0;
        bus_sel_s = 4'b1111;
        case (state_q)
            S_START: begin
                bus_we_s  = 1'b1;
                bus_sel_s = 4'b0001;
                bus_dat_s = 32'd1;
            end
            S_POLL: begin
                bus_we_s  = 1'b0;
            end
            S_RDCNT: begin
                bus_adr_s = 22'h000100 | {14'd0, beam_q};
            end
            S_WRTHR: begin
                bus_we_s  = 1'b1;
                bus_adr_s = 22'h000100 | {14'd0, beam_q};
                bus_sel_s = 4'b0111;
                bus_dat_s = {14'd0, cur_thr_s};
            end
            S_LOAD: begin
                bus_we_s  = 1'b1;
                bus_adr_s = 22'h000200 | {14'd0, beam_q};
                bus_sel_s = 4'b0010;
                bus_dat_s = 32'd1;
            end
            S_APPLY: begin
                bus_we_s  = 1'b1;
                bus_sel_s = 4'b0010;
                bus_dat_s = 32'd2;
            end
            default: begin
                is_bus_s  = 1'b0;
                bus_sel_s = 4'b0000;
            end
        endcase
    end

`ifdef L1_THRESH_SERVO_WB_TIMEOUT_EN
    // Watchdog counts clocks while a transfer is outstanding; restarts per transfer.
    always_comb begin
        if (cyc_q) begin
            to_cnt_d = to_cnt_q + 32'd1;
        end else begin
            to_cnt_d = 32'd0;
        end
    end
`endif

    // Servo sequencer: next-state, bus handshake and threshold update.
    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        we_d         = we_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        sel_d        = sel_q;
        cycle_done_d = 1'b0;
        err_d        = err_q;
        thresh_d     = thresh_q;
        beam_d       = beam_q;
        wait_cnt_d   = wait_cnt_q;
        count_d      = count_q;
        target_d     = target_q;
        tol_d        = tol_q;
        step_d       = step_q;

        if (is_bus_s) begin
            if (!cyc_q) begin
                cyc_d = 1'b1;
                we_d  = bus_we_s;
                adr_d = bus_adr_s;
                dat_d = bus_dat_s;
                sel_d = bus_sel_s;
            end else if (wb_err_i) begin
                cyc_d   = 1'b0;
                err_d   = 1'b1;
                state_d = S_IDLE;
            end else if (wb_rty_i) begin
                // Drop for one idle cycle; the same state re-raises the transfer.
                cyc_d = 1'b0;
            end else if (wb_ack_i) begin
                cyc_d = 1'b0;
                case (state_q)
                    S_START: begin
                        target_d   = target_i;
                        tol_d      = tol_i;
                        step_d     = step_i;
                        wait_cnt_d = 32'd0;
                        state_d    = S_WAIT;
                    end
                    S_POLL: begin
                        if (wb_dat_i[0]) begin
                            beam_d  = 8'd0;
                            state_d = S_RDCNT;
                        end else begin
                            wait_cnt_d = 32'd0;
                            state_d    = S_WAIT;
                        end
                    end
                    S_RDCNT: begin
                        count_d = wb_dat_i;
                        state_d = S_ADJ;
                    end
                    S_WRTHR: begin
                        state_d = S_LOAD;
                    end
                    S_LOAD: begin
                        if (beam_q == 8'(NBEAMS - 1)) begin
                            state_d = S_APPLY;
                        end else begin
                            beam_d  = beam_q + 8'd1;
                            state_d = S_RDCNT;
                        end
                    end
                    S_APPLY: begin
                        cycle_done_d = 1'b1;
                        state_d      = S_FIN;
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
`ifdef L1_THRESH_SERVO_WB_TIMEOUT_EN
            end else if (to_cnt_q == 32'(TIMEOUT_CLOCKS - 1)) begin
                cyc_d   = 1'b0;
                err_d   = 1'b1;
                state_d = S_IDLE;
`endif
            end else begin
                cyc_d = 1'b1;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable_i) begin
                        state_d = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt_q == 32'(POLL_INTERVAL - 1)) begin
                        state_d = S_POLL;
                    end else begin
                        wait_cnt_d = wait_cnt_q + 32'd1;
                    end
                end
                S_ADJ: begin
                    for (int i = 0; i < int'(NBEAMS); i++) begin
                        if (beam_q == 8'(i)) begin
                            thresh_d[i*18 +: 18] = new_thr_s;
                        end else begin
                            thresh_d[i*18 +: 18] = thresh_q[i*18 +: 18];
                        end
                    end
                    state_d = S_WRTHR;
                end
                S_FIN: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs, synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= 22'd0;
            dat_q        <= 32'd0;
            sel_q        <= 4'd0;
            busy_q       <= 1'b0;
            cycle_done_q <= 1'b0;
            err_q        <= 1'b0;
            thresh_q     <= {NBEAMS{INIT_THRESH}};
            beam_q       <= 8'd0;
            wait_cnt_q   <= 32'd0;
            count_q      <= 32'd0;
            target_q     <= 32'd0;
            tol_q        <= 32'd0;
            step_q       <= 18'd0;
`ifdef L1_THRESH_SERVO_WB_TIMEOUT_EN
            to_cnt_q     <= 32'd0;
`endif
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            dat_q        <= dat_d;
            sel_q        <= sel_d;
            busy_q       <= busy_d;
            cycle_done_q <= cycle_done_d;
            err_q        <= err_d;
            thresh_q     <= thresh_d;
            beam_q       <= beam_d;
            wait_cnt_q   <= wait_cnt_d;
            count_q      <= count_d;
            target_q     <= target_d;
            tol_q        <= tol_d;
            step_q       <= step_d;
`ifdef L1_THRESH_SERVO_WB_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_l1_threshold_servo.sv
// Directed bench for l1_threshold_servo with a small Wishbone target model.
module tb_l1_threshold_servo;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        enable;
    logic [31:0] target, tol;
    logic [17:0] step;
    logic        cyc, stb, we;
    logic [21:0] adr;
    logic [31:0] dat_o, dat_i;
    logic [3:0]  sel;
    logic        ack, err, rty;
    logic        busy, cdone, err_o;
    logic [35:0] thresh;

    l1_threshold_servo #(.NBEAMS(2), .POLL_INTERVAL(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .enable_i(enable),
        .target_i(target), .tol_i(tol), .step_i(step),
        .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr),
        .wb_dat_o(dat_o), .wb_sel_o(sel), .wb_dat_i(dat_i),
        .wb_ack_i(ack), .wb_err_i(err), .wb_rty_i(rty),
        .busy_o(busy), .cycle_done_o(cdone), .err_o(err_o), .thresh_o(thresh)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Target-model configuration (written only by the stimulus process).
    int          done_thresh = 1;
    logic [31:0] cnt0 = 32'd0, cnt1 = 32'd0;
    int          rty_allow = 0;
    bit          err_cnt = 1'b0;
    bit          stall_all = 1'b0;

    // Target-model state (written only by the responder process).
    int          poll_n = 0;
    int          rty_used = 0;
    int          pulses = 0;
    int          stable_bad = 0;
    logic [21:0] l_adr[$];
    logic [31:0] l_dat[$];
    logic        l_we[$];
    logic [3:0]  l_sel[$];
    int          l_kind[$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Target model: one wait state, then a single response for one cycle.
    initial begin : responder
        logic        waited, rsp_on;
        logic [21:0] h_adr;
        logic [31:0] h_dat;
        int          kind;
        ack = 1'b0; err = 1'b0; rty = 1'b0; dat_i = 32'd0;
        waited = 1'b0; rsp_on = 1'b0; h_adr = 22'd0; h_dat = 32'd0;
        forever begin
            @(negedge clk);
            if (rsp_on) begin
                ack = 1'b0; err = 1'b0; rty = 1'b0; dat_i = 32'd0; rsp_on = 1'b0;
            end else if (cyc && stb && !stall_all) begin
                if (!waited) begin
                    waited = 1'b1; h_adr = adr; h_dat = dat_o;
                end else begin
                    waited = 1'b0; rsp_on = 1'b1; kind = 0;
                    if (adr !== h_adr || dat_o !== h_dat) stable_bad++;
                    if (we && adr == 22'd0 && sel == 4'b0001 && rty_used < rty_allow) begin
                        rty_used++; rty = 1'b1; kind = 1;
                    end else if (!we && adr == 22'd0) begin
                        poll_n++;
                        dat_i = (poll_n >= done_thresh) ? 32'd1 : 32'd0;
                        ack = 1'b1;
                    end else if (!we && adr[9:8] == 2'b01) begin
                        if (err_cnt) begin
                            err = 1'b1; kind = 2;
                        end else begin
                            dat_i = adr[0] ? cnt1 : cnt0; ack = 1'b1;
                        end
                    end else begin
                        ack = 1'b1;
                    end
                    l_adr.push_back(adr);
                    l_dat.push_back(we ? dat_o : dat_i);
                    l_we.push_back(we);
                    l_sel.push_back(we ? sel : 4'd0);
                    l_kind.push_back(kind);
                end
            end else begin
                waited = 1'b0;
            end
        end
    end

    // Count cycle_done pulses.
    initial begin : pulse_mon
        forever begin
            @(posedge clk);
            #1;
            if (cdone) pulses++;
        end
    end

    int lb;   // log index where the current servo cycle starts
    int pb;   // pulse count when the current servo cycle starts

    task automatic check_x(input string tag, input int i, input logic w, input logic [21:0] a,
                           input logic [3:0] s, input logic [31:0] d);
        check_val(tag, {5'd0, l_we[lb+i], l_adr[lb+i], l_sel[lb+i], l_dat[lb+i]}, {5'd0, w, a, s, d});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One servo cycle; enable drops once busy (or once the start write completes).
    task automatic run_one(input bit drop_at_wait, input int polls_to_done);
        int k;
        lb = l_adr.size();
        pb = pulses;
        done_thresh = poll_n + polls_to_done;
        enable = 1'b1;
        k = 0;
        while (!busy && k < 50) begin @(posedge clk); #1; k++; end
        check_val("busy_rise", busy, 1);
        if (drop_at_wait) begin
            k = 0;
            while (l_adr.size() == lb && k < 100) begin @(posedge clk); #1; k++; end
        end
        enable = 1'b0;
        k = 0;
        while (busy && k < 3000) begin @(posedge clk); #1; k++; end
        check_val("busy_fall", busy, 0);
        repeat (30) @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int k;
        rst = 1'b1; enable = 1'b0; target = 32'd1000; tol = 32'd50; step = 18'd16;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("rst_cyc", {cyc, stb, we}, 3'b000);
        check_val("rst_busy", {busy, cdone, err_o}, 3'b000);
        check_val("rst_bus", {adr, dat_o, sel}, 58'd0);
        check_val("rst_thresh", thresh, {18'd4096, 18'd4096});

        // Basic cycle: counts {1200,800}, done on third poll.
        cnt0 = 32'd1200; cnt1 = 32'd800;
        run_one(1'b0, 3);
        check_val("t1_len", l_adr.size() - lb, 11);
        check_x("t1_start", 0, 1'b1, 22'h000, 4'b0001, 32'd1);
        check_x("t1_poll1", 1, 1'b0, 22'h000, 4'b0000, 32'd0);
        check_x("t1_poll2", 2, 1'b0, 22'h000, 4'b0000, 32'd0);
        check_x("t1_poll3", 3, 1'b0, 22'h000, 4'b0000, 32'd1);
        check_x("t1_rd0", 4, 1'b0, 22'h100, 4'b0000, 32'd1200);
        check_x("t1_wr0", 5, 1'b1, 22'h100, 4'b0111, 32'd4112);
        check_x("t1_ld0", 6, 1'b1, 22'h200, 4'b0010, 32'd1);
        check_x("t1_rd1", 7, 1'b0, 22'h101, 4'b0000, 32'd800);
        check_x("t1_wr1", 8, 1'b1, 22'h101, 4'b0111, 32'd4080);
        check_x("t1_ld1", 9, 1'b1, 22'h201, 4'b0010, 32'd1);
        check_x("t1_apply", 10, 1'b1, 22'h000, 4'b0010, 32'd2);
        check_val("t1_pulses", pulses - pb, 1);
        check_val("t1_thresh", thresh, {18'd4080, 18'd4112});
        check_val("t1_err", err_o, 0);

        // Reset while a transfer is stalled: bus drops on the next edge.
        stall_all = 1'b1;
        enable = 1'b1;
        k = 0;
        while (!cyc && k < 50) begin @(posedge clk); #1; k++; end
        enable = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_val("stall_hold", {cyc, busy}, 2'b11);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_val("rst_mid_cyc", cyc, 0);
        @(negedge clk);
        rst = 1'b0;
        stall_all = 1'b0;
        @(posedge clk); #1;
        check_val("rst2_thresh", thresh, {18'd4096, 18'd4096});
        check_val("rst2_busy", busy, 0);

        // Counts within the dead band; enable dropped during WAIT.
        cnt0 = 32'd1040; cnt1 = 32'd960;
        run_one(1'b1, 1);
        check_val("t2_len", l_adr.size() - lb, 9);
        check_x("t2_wr0", 3, 1'b1, 22'h100, 4'b0111, 32'd4096);
        check_x("t2_ld0", 4, 1'b1, 22'h200, 4'b0010, 32'd1);
        check_x("t2_wr1", 6, 1'b1, 22'h101, 4'b0111, 32'd4096);
        check_x("t2_ld1", 7, 1'b1, 22'h201, 4'b0010, 32'd1);
        check_x("t2_apply", 8, 1'b1, 22'h000, 4'b0010, 32'd2);
        check_val("t2_pulses", pulses - pb, 1);
        check_val("t2_thresh", thresh, {18'd4096, 18'd4096});

        // Saturation: drive beam0 to MAX-5 and beam1 to 20, then step 16.
        step = 18'd258042; cnt0 = 32'd2000; cnt1 = 32'd1000;
        run_one(1'b0, 1);
        check_val("t3a_thresh", thresh, {18'd4096, 18'd262138});
        step = 18'd4076; cnt0 = 32'd1000; cnt1 = 32'd0;
        run_one(1'b0, 1);
        check_val("t3b_thresh", thresh, {18'd20, 18'd262138});
        step = 18'd16; cnt0 = 32'd2000; cnt1 = 32'd0;
        run_one(1'b0, 1);
        check_x("t3c_wr0", 3, 1'b1, 22'h100, 4'b0111, 32'h3FFFF);
        check_x("t3c_wr1", 6, 1'b1, 22'h101, 4'b0111, 32'd16);
        check_val("t3c_thresh", thresh, {18'd16, 18'h3FFFF});

        // Retry on the first start write.
        cnt0 = 32'd1000; cnt1 = 32'd1000;
        rty_allow = rty_used + 1;
        run_one(1'b0, 1);
        check_val("t4_len", l_adr.size() - lb, 10);
        check_val("t4_kind0", l_kind[lb], 1);
        check_x("t4_try0", 0, 1'b1, 22'h000, 4'b0001, 32'd1);
        check_val("t4_kind1", l_kind[lb+1], 0);
        check_x("t4_try1", 1, 1'b1, 22'h000, 4'b0001, 32'd1);
        check_val("t4_pulses", pulses - pb, 1);

        // Error on a count read aborts the cycle.
        err_cnt = 1'b1;
        run_one(1'b0, 1);
        err_cnt = 1'b0;
        check_val("t5_len", l_adr.size() - lb, 3);
        check_val("t5_kind", l_kind[lb+2], 2);
        check_val("t5_state", {err_o, busy, cyc}, 3'b100);
        check_val("t5_pulses", pulses - pb, 0);
        run_one(1'b0, 1);
        check_val("t5_sticky", err_o, 1);
        check_val("t5_pulses2", pulses - pb, 1);

`ifdef L1_THRESH_SERVO_WB_TIMEOUT_EN
        // Watchdog: a silent target is abandoned after 64 clocks.
        do_reset();
        stall_all = 1'b1;
        enable = 1'b1;
        k = 0;
        while (!cyc && k < 50) begin @(posedge clk); #1; k++; end
        enable = 1'b0;
        k = 0;
        while (cyc && k < 200) begin @(posedge clk); #1; k++; end
        check_val("to_len", k, 64);
        check_val("to_state", {err_o, busy, cyc}, 3'b100);
        stall_all = 1'b0;
`endif

        check_val("hold_stable", stable_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
